// File: rtl/io_tile_pkg.sv
// Shared types for the multi-pad IO logical tile: controller state encoding
// and the position of each per-pad field inside a pad's configuration slot.
package io_tile_pkg;

    typedef enum logic [1:0] {
        UNCFG  = 2'd0,
        ACTIVE = 2'd1,
        ERR    = 2'd2
    } io_cfg_state_e;

    localparam int CFG_DIR_BIT = 0;
    localparam int CFG_INV_BIT = 1;

endpackage

// File: rtl/io_pad_slice.sv
// One GPIO pad: tristate output driver, gated/inverted inbound path and,
// when IO_INPUT_SYNC_EN is defined, a 2-flop synchroniser on the inbound bit.
module io_pad_slice (
`ifdef IO_INPUT_SYNC_EN
    input  logic prog_clk,
    input  logic prog_reset,
`endif
    input  logic active,
    input  logic dir,
    input  logic inv,
    input  logic out_data,
    inout  wire  pad,
    output logic in_data
);

    logic pad_sampled;

    // Drive only once the tile is configured and this pad is an output.
    assign pad = (active && dir) ? out_data : 1'bz;

`ifdef IO_INPUT_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    // Held clear outside ACTIVE so stale pad history never leaks after a reload.
    always_ff @(posedge prog_clk) begin
        if (prog_reset || !active) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= pad;
            sync_q2 <= sync_q1;
        end
    end

    assign pad_sampled = sync_q2;
`else
    assign pad_sampled = pad;
`endif

    assign in_data = (active && !dir) ? (pad_sampled ^ inv) : 1'b0;

endmodule

// File: rtl/logical_tile_io_array_cfg.sv
// NUM_IO GPIO pads behind one configuration-chain segment, with a load
// controller that keeps pads safe until a full load is confirmed.
// Optional inbound synchroniser: define IO_INPUT_SYNC_EN.
module logical_tile_io_array_cfg
    import io_tile_pkg::*;
#(
    parameter int NUM_IO          = 4,
    parameter int CFG_BITS_PER_IO = 2
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              cfg_done,
    inout  wire  [NUM_IO-1:0] gfpga_pad_GPIO_PAD,
    input  logic [NUM_IO-1:0] io_outpad,
    input  logic              ccff_head,
    output logic [NUM_IO-1:0] io_inpad,
    output logic              ccff_tail,
    output logic              cfg_err
);

    localparam int CHAIN_LEN = NUM_IO * CFG_BITS_PER_IO;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

    io_cfg_state_e        state;
    io_cfg_state_e        state_next;
    logic [CHAIN_LEN-1:0] cfg_sr;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 load_full;
    logic                 shift_en;
    logic                 cnt_restart;
    logic                 err_next;
    logic                 pads_live;

    assign load_full = (bit_cnt == CNT_W'(CHAIN_LEN));

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state <= UNCFG;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            UNCFG: begin
                if (cfg_done) begin
                    state_next = load_full ? ACTIVE : ERR;
                end
            end
            ACTIVE, ERR: begin
                if (!cfg_done) begin
                    state_next = UNCFG;
                end
            end
            default: state_next = UNCFG;
        endcase
    end

    // Leaving ACTIVE/ERR shifts in the same cycle, so that cycle is bit 1.
    always_comb begin
        shift_en    = 1'b0;
        cnt_restart = 1'b0;
        err_next    = cfg_err;
        case (state)
            UNCFG: begin
                if (!cfg_done) begin
                    shift_en = 1'b1;
                end else begin
                    err_next = !load_full;
                end
            end
            ACTIVE, ERR: begin
                if (!cfg_done) begin
                    shift_en    = 1'b1;
                    cnt_restart = 1'b1;
                    err_next    = 1'b0;
                end
            end
            default: begin
                err_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            cfg_sr  <= '0;
            bit_cnt <= '0;
            cfg_err <= 1'b0;
        end else begin
            if (shift_en) begin
                cfg_sr <= {cfg_sr[CHAIN_LEN-2:0], ccff_head};
            end
            if (cnt_restart) begin
                bit_cnt <= CNT_W'(1);
            end else if (shift_en && !load_full) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            cfg_err <= err_next;
        end
    end

    // MSB is the oldest bit, so the chain delay equals CHAIN_LEN cycles.
    assign ccff_tail = cfg_sr[CHAIN_LEN-1];
    assign pads_live = (state == ACTIVE);

    for (genvar i = 0; i < NUM_IO; i++) begin : g_pad
        io_pad_slice u_pad (
`ifdef IO_INPUT_SYNC_EN
            .prog_clk   (prog_clk),
            .prog_reset (prog_reset),
`endif
            .active     (pads_live),
            .dir        (cfg_sr[CFG_BITS_PER_IO*i + CFG_DIR_BIT]),
            .inv        (cfg_sr[CFG_BITS_PER_IO*i + CFG_INV_BIT]),
            .out_data   (io_outpad[i]),
            .pad        (gfpga_pad_GPIO_PAD[i]),
            .in_data    (io_inpad[i])
        );
    end

endmodule

// File: tb/tb_logical_tile_io_array_cfg.sv
// Self-checking bench for logical_tile_io_array_cfg: directed scenarios plus
// randomized traffic compared against a bit-history reference model.
module tb_logical_tile_io_array_cfg;

    localparam int NUM_IO = 4;
    localparam int BPI    = 2;
    localparam int CL     = NUM_IO * BPI;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_BAD  = 2;

    logic              prog_clk = 1'b0;
    logic              prog_reset;
    logic              cfg_done;
    logic              ccff_head;
    logic [NUM_IO-1:0] io_outpad;
    logic [NUM_IO-1:0] io_inpad;
    logic              ccff_tail;
    logic              cfg_err;
    wire  [NUM_IO-1:0] gfpga_pad_GPIO_PAD;

    logic [NUM_IO-1:0] pad_drv;
    logic [NUM_IO-1:0] pad_en;
    logic              rand_pads;

    int checks   = 0;
    int failures = 0;

    // Reference model: last CL shifted bits, oldest first.
    logic m_hist[$];
    int   m_cnt;
    int   m_mode;
    logic m_err;
    logic m_s1[NUM_IO];
    logic m_s2[NUM_IO];

    logical_tile_io_array_cfg #(.NUM_IO(NUM_IO), .CFG_BITS_PER_IO(BPI)) dut (
        .prog_clk           (prog_clk),
        .prog_reset         (prog_reset),
        .cfg_done           (cfg_done),
        .gfpga_pad_GPIO_PAD (gfpga_pad_GPIO_PAD),
        .io_outpad          (io_outpad),
        .ccff_head          (ccff_head),
        .io_inpad           (io_inpad),
        .ccff_tail          (ccff_tail),
        .cfg_err            (cfg_err)
    );

    for (genvar g = 0; g < NUM_IO; g++) begin : g_drv
        assign gfpga_pad_GPIO_PAD[g] = pad_en[g] ? pad_drv[g] : 1'bz;
    end

    always #5 prog_clk = ~prog_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic m_sr(int k);
        return m_hist[CL-1-k];
    endfunction

    function automatic logic m_dir(int i);
        return m_sr(BPI*i);
    endfunction

    function automatic logic m_inv(int i);
        return m_sr(BPI*i + 1);
    endfunction

    function automatic logic m_drives(int i);
        return (m_mode == M_RUN) && m_dir(i);
    endfunction

    function automatic void model_reset();
        m_hist.delete();
        for (int k = 0; k < CL; k++) m_hist.push_back(1'b0);
        m_cnt  = 0;
        m_mode = M_IDLE;
        m_err  = 1'b0;
        for (int i = 0; i < NUM_IO; i++) begin
            m_s1[i] = 1'b0;
            m_s2[i] = 1'b0;
        end
    endfunction

    function automatic void model_push(logic b);
        m_hist.push_back(b);
        void'(m_hist.pop_front());
        if (m_cnt < CL) m_cnt++;
    endfunction

    function automatic void model_edge(logic rst, logic done, logic head, logic [NUM_IO-1:0] pad_now);
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < NUM_IO; i++) begin
                if (m_mode != M_RUN) begin
                    m_s1[i] = 1'b0;
                    m_s2[i] = 1'b0;
                end else begin
                    m_s2[i] = m_s1[i];
                    m_s1[i] = pad_now[i];
                end
            end
            if (m_mode == M_IDLE) begin
                if (!done) model_push(head);
                else if (m_cnt == CL) m_mode = M_RUN;
                else begin
                    m_mode = M_BAD;
                    m_err  = 1'b1;
                end
            end else if (!done) begin
                m_mode = M_IDLE;
                m_err  = 1'b0;
                model_push(head);
                m_cnt = 1;
            end
        end
    endfunction

    function automatic logic [NUM_IO-1:0] exp_inpad();
        logic [NUM_IO-1:0] r;
        logic src;
        r = '0;
        for (int i = 0; i < NUM_IO; i++) begin
`ifdef IO_INPUT_SYNC_EN
            src = m_s2[i];
`else
            src = pad_drv[i];
`endif
            if (m_mode == M_RUN && !m_dir(i)) r[i] = src ^ m_inv(i);
        end
        return r;
    endfunction

    function automatic logic [NUM_IO-1:0] exp_pads();
        logic [NUM_IO-1:0] r;
        for (int i = 0; i < NUM_IO; i++) r[i] = m_drives(i) ? io_outpad[i] : pad_drv[i];
        return r;
    endfunction

    // Bench releases pads the DUT should drive; elsewhere it drives the
    // opposite of io_outpad so any stray DUT driver shows up as contention.
    task automatic apply_pads();
        for (int i = 0; i < NUM_IO; i++) begin
            pad_en[i] = !m_drives(i);
            if (pad_en[i]) io_outpad[i] = ~pad_drv[i];
        end
    endtask

    task automatic step(input logic rst, input logic done, input logic head);
        logic [NUM_IO-1:0] pad_now;
        prog_reset = rst;
        cfg_done   = done;
        ccff_head  = head;
        if (rand_pads) begin
            pad_drv   = NUM_IO'($urandom);
            io_outpad = NUM_IO'($urandom);
        end
        apply_pads();
        @(posedge prog_clk);
        for (int i = 0; i < NUM_IO; i++) pad_now[i] = pad_en[i] ? pad_drv[i] : io_outpad[i];
        model_edge(rst, done, head, pad_now);
        #1;
        apply_pads();
        #1;
    endtask

    task automatic load_word(input logic [CL-1:0] word);
        for (int k = CL - 1; k >= 0; k--) step(1'b0, 1'b0, word[k]);
        step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rand_pads = 1'b0;
        pad_drv   = '0;
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (io_inpad !== 4'b0000) begin
            failures++;
            $display("FAIL reset_inpad: got %b, required 0000", io_inpad);
        end
        checks++;
        if (cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_cfg_err: got %b, required 0", cfg_err);
        end
        checks++;
        if (ccff_tail !== 1'b0) begin
            failures++;
            $display("FAIL reset_tail: got %b, required 0", ccff_tail);
        end
        checks++;
        if (gfpga_pad_GPIO_PAD !== 4'b0000) begin
            failures++;
            $display("FAIL reset_pads_hiz: got %b, required 0000 (bench-driven 0 vs io_outpad 1111)", gfpga_pad_GPIO_PAD);
        end
    endtask

    task automatic test_full_load();
        rand_pads = 1'b0;
        pad_drv   = '0;
        step(1'b1, 1'b0, 1'b0);
        load_word(8'b0000_0101);
        checks++;
        if (cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL full_load_err: got %b, required 0", cfg_err);
        end
        io_outpad = 4'b0011;
        pad_drv   = 4'b1100;
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (gfpga_pad_GPIO_PAD[1:0] !== 2'b11) begin
            failures++;
            $display("FAIL full_load_out_a: got %b, required 11", gfpga_pad_GPIO_PAD[1:0]);
        end
        checks++;
        if (io_inpad !== 4'b1100) begin
            failures++;
            $display("FAIL full_load_in_a: got %b, required 1100", io_inpad);
        end
        io_outpad = 4'b0010;
        pad_drv   = 4'b0100;
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if (gfpga_pad_GPIO_PAD[1:0] !== 2'b10) begin
            failures++;
            $display("FAIL full_load_out_b: got %b, required 10", gfpga_pad_GPIO_PAD[1:0]);
        end
        checks++;
        if (io_inpad !== 4'b0100) begin
            failures++;
            $display("FAIL full_load_in_b: got %b, required 0100", io_inpad);
        end
    endtask

    task automatic test_invert();
        rand_pads = 1'b0;
        pad_drv   = '0;
        load_word(8'b1000_0000);
        pad_drv = 4'b1000;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (io_inpad !== 4'b0000) begin
            failures++;
            $display("FAIL invert_high: got %b, required 0000", io_inpad);
        end
        pad_drv = 4'b0000;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (io_inpad !== 4'b1000) begin
            failures++;
            $display("FAIL invert_low: got %b, required 1000", io_inpad);
        end
    endtask

    task automatic test_short_load();
        rand_pads = 1'b0;
        pad_drv   = '0;
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (cfg_err !== 1'b1) begin
            failures++;
            $display("FAIL short_load_err: got %b, required 1", cfg_err);
        end
        checks++;
        if (io_inpad !== 4'b0000 || gfpga_pad_GPIO_PAD !== 4'b0000) begin
            failures++;
            $display("FAIL short_load_safe: got inpad=%b pads=%b, required 0000/0000", io_inpad, gfpga_pad_GPIO_PAD);
        end
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (cfg_err !== 1'b1) begin
            failures++;
            $display("FAIL short_load_hold: got %b, required 1", cfg_err);
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL short_load_clear: got %b, required 0", cfg_err);
        end
    endtask

    task automatic test_chain();
        logic heads[16];
        logic want;
        rand_pads = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 16; j++) begin
            heads[j] = 1'($urandom);
            step(1'b0, 1'b0, heads[j]);
            want = (j >= CL - 1) ? heads[j-(CL-1)] : 1'b0;
            checks++;
            if (ccff_tail !== want) begin
                failures++;
                $display("FAIL chain_tail[%0d]: got %b, required %b", j, ccff_tail, want);
            end
        end
    endtask

    task automatic test_sync_latency();
        logic [2:0] want;
        rand_pads = 1'b0;
        pad_drv   = '0;
        step(1'b1, 1'b0, 1'b0);
        load_word(8'b0000_0000);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0);
`ifdef IO_INPUT_SYNC_EN
        want = 3'b100;
`else
        want = 3'b111;
`endif
        pad_drv[2] = 1'b1;
        #1;
        checks++;
        if (io_inpad[2] !== want[0]) begin
            failures++;
            $display("FAIL latency_0: got %b, required %b", io_inpad[2], want[0]);
        end
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (io_inpad[2] !== want[1]) begin
            failures++;
            $display("FAIL latency_1: got %b, required %b", io_inpad[2], want[1]);
        end
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (io_inpad[2] !== want[2]) begin
            failures++;
            $display("FAIL latency_2: got %b, required %b", io_inpad[2], want[2]);
        end
    endtask

    task automatic test_random();
        int low_len;
        int high_len;
        logic rst;
        rand_pads = 1'b1;
        for (int seg = 0; seg < 40; seg++) begin
            low_len  = $urandom_range(0, 11);
            high_len = $urandom_range(1, 5);
            for (int c = 0; c < low_len + high_len; c++) begin
                rst = ($urandom_range(0, 59) == 0);
                step(rst, (c >= low_len), 1'($urandom));
                checks++;
                if (io_inpad !== exp_inpad()) begin
                    failures++;
                    $display("FAIL rand_inpad seg%0d: got %b, required %b", seg, io_inpad, exp_inpad());
                end
                checks++;
                if (gfpga_pad_GPIO_PAD !== exp_pads()) begin
                    failures++;
                    $display("FAIL rand_pads seg%0d: got %b, required %b", seg, gfpga_pad_GPIO_PAD, exp_pads());
                end
                checks++;
                if (cfg_err !== m_err) begin
                    failures++;
                    $display("FAIL rand_cfg_err seg%0d: got %b, required %b", seg, cfg_err, m_err);
                end
                checks++;
                if (ccff_tail !== m_hist[0]) begin
                    failures++;
                    $display("FAIL rand_tail seg%0d: got %b, required %b", seg, ccff_tail, m_hist[0]);
                end
            end
        end
    endtask

    initial begin
        prog_reset = 1'b1;
        cfg_done   = 1'b0;
        ccff_head  = 1'b0;
        pad_drv    = '0;
        io_outpad  = '0;
        rand_pads  = 1'b0;
        model_reset();
        apply_pads();

        test_reset();
        test_full_load();
        test_invert();
        test_short_load();
        test_chain();
        test_sync_latency();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
